// File: rtl/executa_movimentos_pkg.sv
// Shared definitions for the move executor: state codes, move-byte fields and decoder.
package executa_movimentos_pkg;

    typedef enum logic [3:0] {
        INICIAL            = 4'd0,
        PREPARACAO         = 4'd1,
        LE_MEMORIA         = 4'd2,
        DECODIFICA         = 4'd3,
        ACIONA_MOTOR       = 4'd4,
        ESPERA_MOTOR       = 4'd5,
        VERIFICA_REPETICAO = 4'd6,
        ATUALIZA_ADDR      = 4'd7,
        FINAL              = 4'd8,
        ERRO               = 4'd9
    } estado_t;

    localparam logic [7:0] FIM_SEQ = 8'hFF;

    localparam logic [2:0] FACE_U = 3'd0;
    localparam logic [2:0] FACE_D = 3'd1;
    localparam logic [2:0] FACE_F = 3'd2;
    localparam logic [2:0] FACE_B = 3'd3;
    localparam logic [2:0] FACE_L = 3'd4;
    localparam logic [2:0] FACE_R = 3'd5;

    localparam logic [1:0] GIRO_HORARIO = 2'b01;
    localparam logic [1:0] GIRO_ANTI    = 2'b10;
    localparam logic [1:0] GIRO_180     = 2'b11;

    typedef struct packed {
        logic       valido;
        logic [2:0] face;
        logic       sentido;
        logic       meia_volta;
    } movimento_t;

    // A half turn is issued as two clockwise quarter turns, so it decodes as CW.
    function automatic movimento_t decodifica_mov(input logic [7:0] b);
        movimento_t m;
        m.face       = b[2:0];
        m.sentido    = (b[4:3] == GIRO_ANTI);
        m.meia_volta = (b[4:3] == GIRO_180);
        m.valido     = (b[7:5] == 3'b000) && (b[2:0] <= FACE_R) && (b[4:3] != 2'b00);
        return m;
    endfunction

endpackage

// File: rtl/executa_movimentos_if.sv
// Movement RAM read port plus motor driver handshake.
interface executa_movimentos_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] addr_movimento;
    logic [7:0]        dado_movimento;
    logic              partida_motor;
    logic [2:0]        motor_face;
    logic              motor_sentido;
    logic              fim_motor;

    modport master (
        output addr_movimento, partida_motor, motor_face, motor_sentido,
        input  dado_movimento, fim_motor
    );

    modport slave (
        input  addr_movimento, partida_motor, motor_face, motor_sentido,
        output dado_movimento, fim_motor
    );
endinterface

// File: rtl/executa_movimentos_fd.sv
// Datapath: RAM address, decoded move register, half-turn flag, timeout and move counters.
module executa_movimentos_fd
    import executa_movimentos_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              zera,
    input  logic              carrega_mov,
    input  logic              limpa_repete,
    input  logic              zera_timeout,
    input  logic              conta_timeout,
    input  logic              conta_exec,
    input  logic              conta_addr,
    input  logic [7:0]        dado_movimento,
    output logic [ADDR_W-1:0] addr_movimento,
    output logic [2:0]        motor_face,
    output logic              motor_sentido,
    output logic [ADDR_W:0]   num_executados,
    output logic              fim_seq,
    output logic              mov_valido,
    output logic              repete,
    output logic              timeout,
    output logic              fim_addr
);
    localparam int            TW          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT - 1);

    movimento_t    mov;
    logic [TW-1:0] cnt_timeout;

    assign mov        = decodifica_mov(dado_movimento);
    assign fim_seq    = (dado_movimento == FIM_SEQ);
    assign mov_valido = mov.valido;
    assign fim_addr   = &addr_movimento;
    assign timeout    = (cnt_timeout == TIMEOUT_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_movimento <= '0;
            num_executados <= '0;
            motor_face     <= '0;
            motor_sentido  <= 1'b0;
            repete         <= 1'b0;
            cnt_timeout    <= '0;
        end else begin
            if (zera) begin
                addr_movimento <= '0;
                num_executados <= '0;
            end else begin
                if (conta_addr) addr_movimento <= addr_movimento + 1'b1;
                if (conta_exec) num_executados <= num_executados + 1'b1;
            end
            // Face/direction only change on decode, so they stay put for the whole turn.
            if (carrega_mov) begin
                motor_face    <= mov.face;
                motor_sentido <= mov.sentido;
                repete        <= mov.meia_volta;
            end else if (limpa_repete) begin
                repete <= 1'b0;
            end
            if (zera_timeout)                   cnt_timeout <= '0;
            else if (conta_timeout && !timeout) cnt_timeout <= cnt_timeout + 1'b1;
        end
    end

endmodule

// File: rtl/executa_movimentos_uc.sv
// Control FSM: fetches, decodes and sequences motor turns; parar overrides everything.
module executa_movimentos_uc
    import executa_movimentos_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       parar,
    input  logic       fim_motor,
    input  logic       fim_seq,
    input  logic       mov_valido,
    input  logic       repete,
    input  logic       timeout,
    input  logic       fim_addr,
    output logic       zera,
    output logic       carrega_mov,
    output logic       limpa_repete,
    output logic       zera_timeout,
    output logic       conta_timeout,
    output logic       conta_exec,
    output logic       conta_addr,
    output logic       partida_motor,
    output logic       executando,
    output logic       pronto,
    output logic       erro,
    output logic [3:0] db_estado
);
    estado_t estado, proximo;

    always_ff @(posedge clock) begin
        if (reset) estado <= INICIAL;
        else       estado <= proximo;
    end

    always_comb begin
        proximo       = estado;
        zera          = 1'b0;
        carrega_mov   = 1'b0;
        limpa_repete  = 1'b0;
        zera_timeout  = 1'b0;
        conta_timeout = 1'b0;
        conta_exec    = 1'b0;
        conta_addr    = 1'b0;
        partida_motor = 1'b0;
        pronto        = 1'b0;
        erro          = 1'b0;
        db_estado     = estado;
        case (estado)
            INICIAL:      if (iniciar) proximo = PREPARACAO;
            PREPARACAO: begin
                zera    = 1'b1;
                proximo = LE_MEMORIA;
            end
            LE_MEMORIA:   proximo = DECODIFICA;
            DECODIFICA: begin
                if (fim_seq)          proximo = FINAL;
                else if (!mov_valido) proximo = ERRO;
                else begin
                    carrega_mov = 1'b1;
                    proximo     = ACIONA_MOTOR;
                end
            end
            ACIONA_MOTOR: begin
                partida_motor = 1'b1;
                zera_timeout  = 1'b1;
                proximo       = ESPERA_MOTOR;
            end
            ESPERA_MOTOR: begin
                conta_timeout = 1'b1;
                if (fim_motor)    proximo = VERIFICA_REPETICAO;
                else if (timeout) proximo = ERRO;
            end
            VERIFICA_REPETICAO: begin
                if (repete) begin
                    limpa_repete = 1'b1;
                    proximo      = ACIONA_MOTOR;
                end else begin
                    conta_exec = 1'b1;
                    proximo    = ATUALIZA_ADDR;
                end
            end
            ATUALIZA_ADDR: begin
                if (fim_addr) proximo = FINAL;
                else begin
                    conta_addr = 1'b1;
                    proximo    = LE_MEMORIA;
                end
            end
            FINAL: begin
                pronto  = 1'b1;
                proximo = INICIAL;
            end
            ERRO: begin
                erro = 1'b1;
                if (iniciar) proximo = PREPARACAO;
            end
            default: begin
                proximo   = INICIAL;
                db_estado = 4'hF;
            end
        endcase
        // Abort freezes the datapath so addr and count keep their last values.
        if (parar) begin
            proximo      = INICIAL;
            zera         = 1'b0;
            carrega_mov  = 1'b0;
            limpa_repete = 1'b0;
            conta_exec   = 1'b0;
            conta_addr   = 1'b0;
        end
    end

    assign executando = !(estado inside {INICIAL, FINAL, ERRO});

endmodule

// File: rtl/executa_movimentos.sv
// Move executor top: walks the movement RAM and drives the cube motors one turn at a time.
module executa_movimentos
    import executa_movimentos_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iniciar,
    input  logic                 parar,
    executa_movimentos_if.master bus,
    output logic                 executando,
    output logic                 pronto,
    output logic                 erro,
    output logic [ADDR_W:0]      num_executados,
    output logic [3:0]           db_estado
);
    logic zera, carrega_mov, limpa_repete, zera_timeout, conta_timeout, conta_exec, conta_addr;
    logic fim_seq, mov_valido, repete, timeout, fim_addr;

    executa_movimentos_uc u_uc (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .parar         (parar),
        .fim_motor     (bus.fim_motor),
        .fim_seq       (fim_seq),
        .mov_valido    (mov_valido),
        .repete        (repete),
        .timeout       (timeout),
        .fim_addr      (fim_addr),
        .zera          (zera),
        .carrega_mov   (carrega_mov),
        .limpa_repete  (limpa_repete),
        .zera_timeout  (zera_timeout),
        .conta_timeout (conta_timeout),
        .conta_exec    (conta_exec),
        .conta_addr    (conta_addr),
        .partida_motor (bus.partida_motor),
        .executando    (executando),
        .pronto        (pronto),
        .erro          (erro),
        .db_estado     (db_estado)
    );

    executa_movimentos_fd #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) u_fd (
        .clock          (clock),
        .reset          (reset),
        .zera           (zera),
        .carrega_mov    (carrega_mov),
        .limpa_repete   (limpa_repete),
        .zera_timeout   (zera_timeout),
        .conta_timeout  (conta_timeout),
        .conta_exec     (conta_exec),
        .conta_addr     (conta_addr),
        .dado_movimento (bus.dado_movimento),
        .addr_movimento (bus.addr_movimento),
        .motor_face     (bus.motor_face),
        .motor_sentido  (bus.motor_sentido),
        .num_executados (num_executados),
        .fim_seq        (fim_seq),
        .mov_valido     (mov_valido),
        .repete         (repete),
        .timeout        (timeout),
        .fim_addr       (fim_addr)
    );

endmodule
